// File: rtl/cpu_pkg.sv
// Shared CPU constants: reset PC, instruction memory window, exception codes.
package cpu_pkg;
  localparam logic [31:0] PC_RESET  = 32'h0000_3000;
  localparam logic [31:0] IM_BASE   = 32'h0000_3000;
  localparam logic [31:0] IM_LIMIT  = 32'h0000_6FFC;
  localparam logic [4:0]  EXC_ADEL  = 5'd4;
  localparam logic [31:0] INSTR_NOP = 32'h0000_0000;
endpackage

// File: rtl/f_pc_reg.sv
// Program counter register: loads npc as-is each edge unless stalled; async reset to PC_RESET.
module f_pc_reg
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [31:0] npc,
  output logic [31:0] pc
);
  logic [31:0] pc_d;
  logic [31:0] pc_q;

  always_comb begin
    pc_d = pc_q;
    if (!stall) pc_d = npc;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) pc_q <= PC_RESET;
    else       pc_q <= pc_d;
  end

  assign pc = pc_q;
endmodule

// File: rtl/f_fetch_stage.sv
// Instruction fetch stage: PC register, optional AdEL fetch check, IF/ID pipeline register.
// Define F_ADEL_CHECK_EN to compile in the fetch address check.
module f_fetch_stage
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] npc,
  input  logic        stall,
  input  logic        D_clr,
  input  logic [31:0] F_instr,
  output logic [31:0] F_pc,
  output logic [31:0] D_pc,
  output logic [31:0] D_instr,
  output logic        D_valid,
  output logic        D_exc,
  output logic [4:0]  D_exccode
);
  logic        f_exc;
  logic [4:0]  f_exccode;
  logic [31:0] f_instr_eff;

  logic [31:0] d_pc_d, d_pc_q;
  logic [31:0] d_instr_d, d_instr_q;
  logic        d_valid_d, d_valid_q;
  logic        d_exc_d, d_exc_q;
  logic [4:0]  d_exccode_d, d_exccode_q;

  f_pc_reg u_pc_reg (
    .clk   (clk),
    .reset (reset),
    .stall (stall),
    .npc   (npc),
    .pc    (F_pc)
  );

`ifdef F_ADEL_CHECK_EN
  // Misaligned or outside the instruction memory window.
  always_comb begin
    f_exc       = (F_pc[1:0] != 2'b00) || (F_pc < IM_BASE) || (F_pc > IM_LIMIT);
    f_exccode   = f_exc ? EXC_ADEL : 5'd0;
    f_instr_eff = f_exc ? INSTR_NOP : F_instr;
  end
`else
  always_comb begin
    f_exc       = 1'b0;
    f_exccode   = 5'd0;
    f_instr_eff = F_instr;
  end
`endif

  // Stall wins over clear; a clear keeps the PC so the bubble stays traceable.
  always_comb begin
    d_pc_d      = d_pc_q;
    d_instr_d   = d_instr_q;
    d_valid_d   = d_valid_q;
    d_exc_d     = d_exc_q;
    d_exccode_d = d_exccode_q;
    if (!stall) begin
      d_pc_d = F_pc;
      if (D_clr) begin
        d_instr_d   = INSTR_NOP;
        d_valid_d   = 1'b0;
        d_exc_d     = 1'b0;
        d_exccode_d = 5'd0;
      end else begin
        d_instr_d   = f_instr_eff;
        d_valid_d   = 1'b1;
        d_exc_d     = f_exc;
        d_exccode_d = f_exccode;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      d_pc_q      <= PC_RESET;
      d_instr_q   <= INSTR_NOP;
      d_valid_q   <= 1'b0;
      d_exc_q     <= 1'b0;
      d_exccode_q <= 5'd0;
    end else begin
      d_pc_q      <= d_pc_d;
      d_instr_q   <= d_instr_d;
      d_valid_q   <= d_valid_d;
      d_exc_q     <= d_exc_d;
      d_exccode_q <= d_exccode_d;
    end
  end

  assign D_pc      = d_pc_q;
  assign D_instr   = d_instr_q;
  assign D_valid   = d_valid_q;
  assign D_exc     = d_exc_q;
  assign D_exccode = d_exccode_q;
endmodule

// File: tb/tb_f_fetch_stage.sv
// Directed bench for f_fetch_stage: reset, sequential fetch, stall, clear, AdEL check, async reset.
module tb_f_fetch_stage;
  logic        clk;
  logic        reset;
  logic [31:0] npc;
  logic        stall;
  logic        D_clr;
  logic [31:0] F_instr;
  logic [31:0] F_pc;
  logic [31:0] D_pc;
  logic [31:0] D_instr;
  logic        D_valid;
  logic        D_exc;
  logic [4:0]  D_exccode;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef F_ADEL_CHECK_EN
  localparam bit ADEL_ON = 1'b1;
`else
  localparam bit ADEL_ON = 1'b0;
`endif

  f_fetch_stage dut (
    .clk       (clk),
    .reset     (reset),
    .npc       (npc),
    .stall     (stall),
    .D_clr     (D_clr),
    .F_instr   (F_instr),
    .F_pc      (F_pc),
    .D_pc      (D_pc),
    .D_instr   (D_instr),
    .D_valid   (D_valid),
    .D_exc     (D_exc),
    .D_exccode (D_exccode)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // advance one edge and settle away from it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] n, input logic [31:0] ins, input logic s, input logic c);
    npc = n; F_instr = ins; stall = s; D_clr = c;
  endtask

  task automatic check_d(input string tag, input logic [31:0] pc, input logic [31:0] ins,
                         input logic v);
    check({tag, ".D_pc"}, D_pc, pc);
    check({tag, ".D_instr"}, D_instr, ins);
    check({tag, ".D_valid"}, {31'd0, D_valid}, {31'd0, v});
  endtask

  initial begin
    reset = 1'b1;
    drive(32'h0, 32'h0, 1'b0, 1'b0);
    #12;
    check("rst.F_pc", F_pc, 32'h3000);
    check_d("rst", 32'h3000, 32'h0, 1'b0);
    check("rst.D_exc", {31'd0, D_exc}, 32'd0);
    check("rst.D_exccode", {27'd0, D_exccode}, 32'd0);

    // sequential fetch from 0x3000
    step();
    reset = 1'b0;
    drive(32'h3004, 32'h1111_1111, 1'b0, 1'b0);
    check("seq0.F_pc", F_pc, 32'h3000);
    step();
    check("seq1.F_pc", F_pc, 32'h3004);
    check_d("seq1", 32'h3000, 32'h1111_1111, 1'b1);
    drive(32'h3008, 32'h2222_2222, 1'b0, 1'b0);
    step();
    check("seq2.F_pc", F_pc, 32'h3008);
    check_d("seq2", 32'h3004, 32'h2222_2222, 1'b1);
    drive(32'h300C, 32'h2222_3333, 1'b0, 1'b0);
    step();
    drive(32'h3010, 32'h2222_4444, 1'b0, 1'b0);
    step();
    check("seq4.F_pc", F_pc, 32'h3010);
    check_d("seq4", 32'h300C, 32'h2222_4444, 1'b1);

    // two stalled edges freeze everything
    drive(32'h3014, 32'h3333_3333, 1'b1, 1'b0);
    step();
    step();
    check("stall.F_pc", F_pc, 32'h3010);
    check_d("stall", 32'h300C, 32'h2222_4444, 1'b1);
    stall = 1'b0;
    step();
    check("unstall.F_pc", F_pc, 32'h3014);
    check_d("unstall", 32'h3010, 32'h3333_3333, 1'b1);

    // clear annuls the incoming instruction but keeps its PC
    drive(32'h3018, 32'h2408_0001, 1'b0, 1'b1);
    step();
    check("clr.F_pc", F_pc, 32'h3018);
    check_d("clr", 32'h3014, 32'h0, 1'b0);
    drive(32'h301C, 32'h4444_4444, 1'b0, 1'b0);
    step();
    check_d("postclr", 32'h3018, 32'h4444_4444, 1'b1);

    // stall beats clear
    drive(32'h3020, 32'h5555_0000, 1'b1, 1'b1);
    step();
    check("stclr.F_pc", F_pc, 32'h301C);
    check_d("stclr", 32'h3018, 32'h4444_4444, 1'b1);

    // misaligned fetch
    drive(32'h3002, 32'h5555_5555, 1'b0, 1'b0);
    step();
    drive(32'h7000, 32'h6666_6666, 1'b0, 1'b0);
    step();
    check_d("mis", 32'h3002, ADEL_ON ? 32'h0 : 32'h6666_6666, 1'b1);
    check("mis.D_exc", {31'd0, D_exc}, {31'd0, ADEL_ON});
    check("mis.D_exccode", {27'd0, D_exccode}, ADEL_ON ? 32'd4 : 32'd0);

    // above the window
    drive(32'h6FFC, 32'h7777_7777, 1'b0, 1'b0);
    step();
    check_d("hi", 32'h7000, ADEL_ON ? 32'h0 : 32'h7777_7777, 1'b1);
    check("hi.D_exc", {31'd0, D_exc}, {31'd0, ADEL_ON});
    check("hi.D_exccode", {27'd0, D_exccode}, ADEL_ON ? 32'd4 : 32'd0);

    // last legal word, then wrap-around addresses loaded as-is
    drive(32'hFFFF_FFFC, 32'h8888_8888, 1'b0, 1'b0);
    step();
    check_d("lim", 32'h6FFC, 32'h8888_8888, 1'b1);
    check("lim.D_exc", {31'd0, D_exc}, 32'd0);
    check("lim.F_pc", F_pc, 32'hFFFF_FFFC);
    drive(32'h0000_0000, 32'h9999_9999, 1'b0, 1'b0);
    step();
    check("wrap.F_pc", F_pc, 32'h0);
    check("wrap.D_exc", {31'd0, D_exc}, {31'd0, ADEL_ON});

    // async reset in the middle of a stall
    drive(32'h3400, 32'hAAAA_AAAA, 1'b0, 1'b0);
    step();
    drive(32'h3404, 32'hBBBB_BBBB, 1'b1, 1'b0);
    step();
    check("pre.F_pc", F_pc, 32'h3400);
    #2;
    reset = 1'b1;
    #1;
    check("arst.F_pc", F_pc, 32'h3000);
    check_d("arst", 32'h3000, 32'h0, 1'b0);
    step();
    check("arsthold.F_pc", F_pc, 32'h3000);
    reset = 1'b0;
    drive(32'h3004, 32'hCCCC_CCCC, 1'b0, 1'b0);
    step();
    check("rel.F_pc", F_pc, 32'h3004);
    check_d("rel", 32'h3000, 32'hCCCC_CCCC, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/f_fetch_stage.md
F_FETCH_STAGE -- requirements
Module: f_fetch_stage

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port npc, input, 32 bits: next fetch address from the decode-stage next-PC logic, sampled at the edge.
REQ-004 SHALL have port stall, input, 1 bit: hazard-unit stall; freezes the PC and the IF/ID register.
REQ-005 SHALL have port D_clr, input, 1 bit: annuls the instruction entering IF/ID (unexecuted delay slot of an untaken branch-likely).
REQ-006 SHALL have port F_instr, input, 32 bits: instruction memory read data for F_pc, combinational.
REQ-007 SHALL have port F_pc, output, 32 bits: current fetch address, driven to instruction memory.
REQ-008 SHALL have port D_pc, output, 32 bits: PC of the instruction held in IF/ID.
REQ-009 SHALL have port D_instr, output, 32 bits: instruction held in IF/ID.
REQ-010 SHALL have port D_valid, output, 1 bit: 1 when IF/ID holds a real, non-annulled instruction.
REQ-011 SHALL have port D_exc, output, 1 bit: fetch-exception flag travelling with the IF/ID instruction (Configuration).
REQ-012 SHALL have port D_exccode, output, 5 bits: exception code for D_exc.

Function
REQ-013 SHALL register F_pc <= npc at each rising edge when stall=0, and hold F_pc when stall=1.
REQ-014 SHALL load IF/ID at each edge when stall=0 as D_pc <= F_pc, D_instr <= F_instr, D_valid <= 1, with D_exc/D_exccode taken from the fetch check.
REQ-015 SHALL hold D_pc, D_instr, D_valid, D_exc and D_exccode unchanged when stall=1.
REQ-016 SHALL load D_pc <= F_pc, D_instr <= 0, D_valid <= 0, D_exc <= 0, D_exccode <= 0 when stall=0 and D_clr=1; PC advances normally.
REQ-017 SHALL give stall priority over D_clr when both are 1: everything holds and the clear is dropped.
REQ-018 SHALL have a latency of exactly one cycle from F_pc to D_pc when there is no stall; no bubbles are inserted except by D_clr.
REQ-019 SHALL NOT add to or modify npc: sequential +4 and branch targets are computed upstream, and npc is loaded as-is, wrapping at 0xFFFF_FFFC.
REQ-020 SHALL substitute instruction 0 in IF/ID when the fetch check flags an exception; F_instr is ignored.

Reset
REQ-021 SHALL set F_pc = 0x0000_3000 immediately on reset=1, independent of clk.
REQ-022 SHALL set D_pc = 0x0000_3000, D_instr = 0, D_valid = 0, D_exc = 0 and D_exccode = 0 on reset.
REQ-023 SHALL let reset override stall and D_clr, including mid-stall, and SHALL perform the first fetch at 0x3000 on the first edge after release.

Configuration
REQ-024 SHALL provide the macro F_ADEL_CHECK_EN to compile the fetch address check in or out.
REQ-025 SHALL, with F_ADEL_CHECK_EN defined, flag F_pc[1:0] != 0, F_pc < 0x3000 or F_pc > 0x6FFC as exception code 4 (AdEL).
REQ-026 SHALL, with F_ADEL_CHECK_EN undefined, tie D_exc and D_exccode to 0 and never substitute the instruction.

Structure
REQ-027 SHALL take PC_RESET (0x3000), IM_BASE (0x3000), IM_LIMIT (0x6FFC), EXC_ADEL (5'd4) and INSTR_NOP (0) from the shared package cpu_pkg.
REQ-028 SHALL place the PC register with stall hold and async reset in one sub-module, f_pc_reg; the IF/ID register and the fetch check stay in the top level.

Verification
REQ-029 SHALL pass: release reset with npc = F_pc+4 and no stall -> F_pc = 0x3000, 0x3004, 0x3008; D_pc lags by one cycle; D_valid = 1 from the second edge.
REQ-030 SHALL pass: stall=1 for 2 cycles with F_pc = 0x3010 and npc = 0x3014 -> F_pc, D_pc and D_instr are frozen; after release F_pc = 0x3014 one edge later.
REQ-031 SHALL pass: D_clr=1 at one edge with F_instr = 0x2408_0001 -> D_instr = 0, D_valid = 0, D_pc = fetched PC; the next edge loads normally.
REQ-032 SHALL pass: stall=1 and D_clr=1 at the same edge -> IF/ID is unchanged, D_valid stays 1.
REQ-033 SHALL pass with F_ADEL_CHECK_EN defined: npc = 0x3002 -> next edge D_exc = 1, D_exccode = 4, D_instr = 0; npc = 0x7000 -> same result; without the macro D_exc = 0 in both cases.
REQ-034 SHALL pass: reset asserted between edges during a stall with F_pc = 0x3400 -> F_pc = 0x3000 and D_valid = 0 before the next edge.
